fsk_frame_ctrl: RTL

Frame controller for the FSK receive path. Sits beside the 16-bit serial-to-parallel deserializer on `clk_16`, watches the same received bit stream for a 16-bit sync word, then counts payload bits and produces the `trans_enable` strobe that latches each completed word. It also reports frame boundaries and loss of sync to downstream logic.

---
 rtl/fsk_ctrl_pkg.sv | 13 +
 rtl/fsk_sync_detect.sv | 49 ++++
 rtl/fsk_frame_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fsk_ctrl_pkg.sv
// rtl/fsk_ctrl_pkg.sv - shared types and constants for the FSK frame controller
// Contents: fsk_state_t (ST_HUNT, ST_RECV), SYNC_WORD_DEF, WIDX_W.
package fsk_ctrl_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } fsk_state_t;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
    localparam int          WIDX_W        = 8;

endpackage

// File: rtl/fsk_sync_detect.sv
// rtl/fsk_sync_detect.sv - sync word hunter: shift register, fill counter, comparator
// Ports:
//   clk_16   in  bit-rate clock
//   reset    in  asynchronous active-low reset
//   bit_en   in  shift sig_reb into the hunt register this cycle
//   sig_reb  in  received bit (first received bit ends up as MSB)
//   clear    in  empty the hunt register and fill counter on the next edge
//   match    out combinational; the post-shift window is full and equals SYNC_WORD
module fsk_sync_detect
    import fsk_ctrl_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic clk_16,
    input  logic reset,
    input  logic bit_en,
    input  logic sig_reb,
    input  logic clear,
    output logic match
);

    logic [15:0] hunt_q;
    logic [15:0] hunt_d;
    logic [4:0]  fill_q;
    logic [4:0]  fill_d;

    always_comb begin
        hunt_d = {hunt_q[14:0], sig_reb};
        fill_d = (fill_q == 5'd16) ? fill_q : fill_q + 5'd1;
    end

    // Evaluated on the value the register will hold after this shift, so
    // the 16th sync bit is recognised in the same cycle it arrives.
    assign match = bit_en && !clear && (fill_d == 5'd16) && (hunt_d == SYNC_WORD);

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            hunt_q <= 16'd0;
            fill_q <= 5'd0;
        end else if (clear) begin
            hunt_q <= 16'd0;
            fill_q <= 5'd0;
        end else if (bit_en) begin
            hunt_q <= hunt_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/fsk_frame_ctrl.sv
// rtl/fsk_frame_ctrl.sv - FSK receive frame controller: sync hunt, word strobes, frame/timeout events
// Optional feature macro: FSK_SYNC_TIMEOUT_EN (idle timeout in RECV driving sync_lost).
// Ports:
//   clk_16       in  bit-rate clock shared with the deserializer
//   reset        in  asynchronous active-low reset
//   sig_reb      in  received demodulated bit
//   bit_en       in  qualifies sig_reb this cycle
//   trans_enable out one-cycle latch strobe for the deserializer parallel register
//   in_frame     out high while receiving payload
//   word_idx     out index of the word latched by the current trans_enable
//   frame_done   out one-cycle pulse with the last word's trans_enable
//   sync_lost    out one-cycle pulse on idle timeout (0 without FSK_SYNC_TIMEOUT_EN)
module fsk_frame_ctrl
    import fsk_ctrl_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int          FRAME_WORDS = 4,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic              clk_16,
    input  logic              reset,
    input  logic              sig_reb,
    input  logic              bit_en,
    output logic              trans_enable,
    output logic              in_frame,
    output logic [WIDX_W-1:0] word_idx,
    output logic              frame_done,
    output logic              sync_lost
);

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(FRAME_WORDS - 1);

    fsk_state_t        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WIDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [WIDX_W-1:0] word_idx_d;
    logic              te_d;
    logic              fd_d;
    logic              clear_hunt;
    logic              hunt_en;
    logic              match;

`ifdef FSK_SYNC_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYC);
    logic [15:0] idle_q, idle_d;
    logic        sl_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Payload bits must never reach the hunt register.
    assign hunt_en = bit_en && (state_q == ST_HUNT);

    fsk_sync_detect #(
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk_16  (clk_16),
        .reset   (reset),
        .bit_en  (hunt_en),
        .sig_reb (sig_reb),
        .clear   (clear_hunt),
        .match   (match)
    );

    assign in_frame = (state_q == ST_RECV);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx;
        te_d       = 1'b0;
        fd_d       = 1'b0;
        clear_hunt = 1'b0;
`ifdef FSK_SYNC_TIMEOUT_EN
        idle_d     = idle_q;
        sl_d       = 1'b0;
`endif
        case (state_q)
            ST_HUNT: begin
                if (match) begin
                    state_d    = ST_RECV;
                    bit_cnt_d  = 4'd0;
                    word_cnt_d = '0;
                    word_idx_d = '0;
`ifdef FSK_SYNC_TIMEOUT_EN
                    idle_d     = 16'd0;
`endif
                end
            end
            ST_RECV: begin
                if (bit_en) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef FSK_SYNC_TIMEOUT_EN
                    idle_d    = 16'd0;
`endif
                    if (bit_cnt_q == 4'd15) begin
                        te_d       = 1'b1;
                        // word_idx reports the word being latched now; the
                        // running counter moves on to the next word.
                        word_idx_d = word_cnt_q;
                        if (word_cnt_q == LAST_WORD) begin
                            fd_d       = 1'b1;
                            state_d    = ST_HUNT;
                            clear_hunt = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef FSK_SYNC_TIMEOUT_EN
                else if (({1'b0, idle_q} + 17'd1) >= TIMEOUT_LIM) begin
                    sl_d       = 1'b1;
                    state_d    = ST_HUNT;
                    clear_hunt = 1'b1;
                    idle_d     = 16'd0;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            bit_cnt_q    <= 4'd0;
            word_cnt_q   <= '0;
            word_idx     <= '0;
            trans_enable <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_idx     <= word_idx_d;
            trans_enable <= te_d;
            frame_done   <= fd_d;
        end
    end

`ifdef FSK_SYNC_TIMEOUT_EN
    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            idle_q    <= 16'd0;
            sync_lost <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            sync_lost <= sl_d;
        end
    end
`else
    assign sync_lost = 1'b0;
`endif

endmodule
